// File: rtl/pspin_hostmem_dma_rd_arb.sv
// Round-robin arbiter sharing the single host-memory DMA read datapath between
// several AXI read masters; one burst in flight, R beats routed to the owner.
//
// state | meaning
// IDLE  | arbitrating upstream AR requests
// ADDR  | captured AR presented downstream
// DATA  | R beats routed to the granted port until RLAST
module pspin_hostmem_dma_rd_arb #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 8,
  parameter int CNT_WIDTH  = 16,
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_PORTS*ID_WIDTH-1:0]   s_axi_arid,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [NUM_PORTS*8-1:0]          s_axi_arlen,
  input  logic [NUM_PORTS*3-1:0]          s_axi_arsize,
  input  logic [NUM_PORTS*2-1:0]          s_axi_arburst,
  input  logic [NUM_PORTS-1:0]            s_axi_arvalid,
  output logic [NUM_PORTS-1:0]            s_axi_arready,
  output logic [NUM_PORTS*ID_WIDTH-1:0]   s_axi_rid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] s_axi_rdata,
  output logic [NUM_PORTS*2-1:0]          s_axi_rresp,
  output logic [NUM_PORTS-1:0]            s_axi_rlast,
  output logic [NUM_PORTS-1:0]            s_axi_rvalid,
  input  logic [NUM_PORTS-1:0]            s_axi_rready,
  output logic [ID_WIDTH-1:0]             m_axi_arid,
  output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic [7:0]                      m_axi_arlen,
  output logic [2:0]                      m_axi_arsize,
  output logic [1:0]                      m_axi_arburst,
  output logic                            m_axi_arlock,
  output logic [3:0]                      m_axi_arcache,
  output logic [2:0]                      m_axi_arprot,
  output logic [3:0]                      m_axi_arqos,
  output logic [3:0]                      m_axi_arregion,
  output logic                            m_axi_aruser,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [ID_WIDTH-1:0]             m_axi_rid,
  input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic [1:0]                      m_axi_rresp,
  input  logic                            m_axi_rlast,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  output logic                            busy,
  output logic [PW-1:0]                   grant_idx,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  done_cnt,
  output logic                            len_err,
  input  logic                            len_err_clr
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] grant_q;
  logic [8:0]    beat_cnt;
  logic [8:0]    beat_nxt;
  logic [8:0]    len_exp;
  logic          win_vld;
  logic [PW-1:0] win_idx;
  int            cand;
  logic          r_beat;
  logic          len_set;

  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arqos    = 4'b0000;
  assign m_axi_arregion = 4'b0000;
  assign m_axi_aruser   = 1'b0;

  assign m_axi_arvalid = (state == ADDR);
  assign busy          = (state != IDLE);
  assign grant_idx     = grant_q;

  // first requester at or above rr_ptr, wrapping
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_PORTS;
      if (!win_vld && s_axi_arvalid[cand]) begin
        win_vld = 1'b1;
        win_idx = PW'(cand);
      end
    end
  end

  always_comb begin
    s_axi_arready = '0;
    if (rstn && state == IDLE && win_vld) s_axi_arready[win_idx] = 1'b1;
  end

  always_comb begin
    s_axi_rid    = '0;
    s_axi_rdata  = '0;
    s_axi_rresp  = '0;
    s_axi_rlast  = '0;
    s_axi_rvalid = '0;
    m_axi_rready = 1'b0;
    if (state == DATA) begin
      s_axi_rid[grant_q*ID_WIDTH +: ID_WIDTH]       = m_axi_rid;
      s_axi_rdata[grant_q*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
      s_axi_rresp[grant_q*2 +: 2]                   = m_axi_rresp;
      s_axi_rlast[grant_q]                          = m_axi_rlast;
      s_axi_rvalid[grant_q]                         = m_axi_rvalid;
      m_axi_rready                                  = s_axi_rready[grant_q];
    end
  end

  assign r_beat   = m_axi_rvalid & m_axi_rready;
  assign beat_nxt = beat_cnt + 9'd1;
  assign len_exp  = {1'b0, m_axi_arlen} + 9'd1;
  // early RLAST, or the counted length reached without RLAST
  assign len_set  = r_beat && (m_axi_rlast ? (beat_nxt != len_exp) : (beat_nxt == len_exp));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant_q       <= '0;
      beat_cnt      <= '0;
      done_cnt      <= '0;
      m_axi_arid    <= '0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      m_axi_arsize  <= '0;
      m_axi_arburst <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            grant_q       <= win_idx;
            m_axi_arid    <= s_axi_arid[win_idx*ID_WIDTH +: ID_WIDTH];
            m_axi_araddr  <= s_axi_araddr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
            m_axi_arlen   <= s_axi_arlen[win_idx*8 +: 8];
            m_axi_arsize  <= s_axi_arsize[win_idx*3 +: 3];
            m_axi_arburst <= s_axi_arburst[win_idx*2 +: 2];
            beat_cnt      <= '0;
            state         <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) state <= DATA;
        end
        DATA: begin
          if (r_beat) begin
            beat_cnt <= beat_nxt;
            if (m_axi_rlast) begin
              state  <= IDLE;
              rr_ptr <= (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
              done_cnt[grant_q*CNT_WIDTH +: CNT_WIDTH] <=
                done_cnt[grant_q*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            len_err <= 1'b0;
    else if (len_set)     len_err <= 1'b1;
    else if (len_err_clr) len_err <= 1'b0;
  end

endmodule

// File: tb/tb_pspin_hostmem_dma_rd_arb.sv
// Scoreboard bench for pspin_hostmem_dma_rd_arb: randomized upstream masters and
// downstream slave, transaction-level reference model, directed corner cases.
module tb_pspin_hostmem_dma_rd_arb;
  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 8;
  localparam int CW = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [NP*IW-1:0] s_arid;
  logic [NP*AW-1:0] s_araddr;
  logic [NP*8-1:0]  s_arlen;
  logic [NP*3-1:0]  s_arsize;
  logic [NP*2-1:0]  s_arburst;
  logic [NP-1:0]    s_arvalid, s_arready;
  logic [NP*IW-1:0] s_rid;
  logic [NP*DW-1:0] s_rdata;
  logic [NP*2-1:0]  s_rresp;
  logic [NP-1:0]    s_rlast, s_rvalid, s_rready;
  logic [IW-1:0]    m_arid;
  logic [AW-1:0]    m_araddr;
  logic [7:0]       m_arlen;
  logic [2:0]       m_arsize;
  logic [1:0]       m_arburst;
  logic             m_arlock, m_aruser, m_arvalid;
  logic [3:0]       m_arcache, m_arqos, m_arregion;
  logic [2:0]       m_arprot;
  logic             m_arready;
  logic [IW-1:0]    m_rid;
  logic [DW-1:0]    m_rdata;
  logic [1:0]       m_rresp;
  logic             m_rlast, m_rvalid, m_rready;
  logic             busy, len_err, len_err_clr;
  logic [1:0]       grant_idx;
  logic [NP*CW-1:0] done_cnt;

  pspin_hostmem_dma_rd_arb #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen),
    .s_axi_arsize(s_arsize), .s_axi_arburst(s_arburst),
    .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
    .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp),
    .s_axi_rlast(s_rlast), .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
    .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst),
    .m_axi_arlock(m_arlock), .m_axi_arcache(m_arcache), .m_axi_arprot(m_arprot),
    .m_axi_arqos(m_arqos), .m_axi_arregion(m_arregion), .m_axi_aruser(m_aruser),
    .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp),
    .m_axi_rlast(m_rlast), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .busy(busy), .grant_idx(grant_idx), .done_cnt(done_cnt),
    .len_err(len_err), .len_err_clr(len_err_clr)
  );

  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
  } ar_t;

  typedef struct packed {
    logic [7:0]    port;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } r_t;

  ar_t exp_ar[$];
  r_t  exp_r[$];
  int  grant_log[$];

  int vectors = 0;
  int errors  = 0;

  // stimulus controls
  int            req_left[NP] = '{default: 0};
  logic          eager = 1'b0;
  logic          fx_en = 1'b0;
  logic [IW-1:0] fx_id = '0;
  logic [AW-1:0] fx_addr = '0;
  logic [7:0]    fx_len = '0;
  int            rready_pct = 100;
  int            ar_delay_fixed = -1;
  int            beats_override = 0;
  int            gap_pct = 20;

  // handshakes sampled on the falling edge, consumed after the next rising edge
  logic [NP-1:0] ar_hs_n  = '0;
  logic          m_r_hs_n = 1'b0;

  // reference model: 0 idle, 1 address pending, 2 data
  int   phase = 0;
  int   owner = 0;
  int   ptr   = 0;
  int   mgrant = 0;
  int   beats = 0;
  int   mlen  = 0;
  logic mlen_err = 1'b0;
  int   mdone[NP] = '{default: 0};

  int   sst = 0;
  int   ar_wait = -1;
  int   nb = 0;
  int   bi = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // upstream masters
  initial begin
    s_arvalid = '0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_rready = '1;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        s_arvalid = '0;
        for (int p = 0; p < NP; p++) req_left[p] = 0;
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (ar_hs_n[p]) begin
            s_arvalid[p] = 1'b0;
            req_left[p]--;
          end
          if (!s_arvalid[p] && req_left[p] > 0 && (eager || $urandom_range(0, 3) == 0)) begin
            s_arid[p*IW +: IW]   = fx_en ? fx_id   : IW'($urandom);
            s_araddr[p*AW +: AW] = fx_en ? fx_addr : AW'($urandom);
            s_arlen[p*8 +: 8]    = fx_en ? fx_len  : 8'($urandom_range(0, 7));
            s_arsize[p*3 +: 3]   = 3'($urandom_range(0, 6));
            s_arburst[p*2 +: 2]  = 2'($urandom_range(0, 2));
            s_arvalid[p] = 1'b1;
          end
        end
      end
      for (int p = 0; p < NP; p++) s_rready[p] = ($urandom_range(0, 99) < rready_pct);
    end
  end

  // downstream slave: accepts AR after a delay, returns nb beats
  initial begin
    r_t e;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        sst = 0; ar_wait = -1;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
      end else begin
        case (sst)
          0: if (m_arvalid) begin
            if (ar_wait < 0) ar_wait = (ar_delay_fixed >= 0) ? ar_delay_fixed : $urandom_range(0, 2);
            if (ar_wait == 0) begin
              m_arready = 1'b1;
              sst = 1;
              ar_wait = -1;
            end else ar_wait--;
          end
          1: begin
            m_arready = 1'b0;
            nb = (beats_override > 0) ? beats_override : int'(m_arlen) + 1;
            m_rid = m_arid;
            bi = 0;
            sst = 2;
          end
          default: begin
            if (m_rvalid && m_r_hs_n) begin
              m_rvalid = 1'b0;
              m_rlast  = 1'b0;
              bi++;
              if (bi == nb) sst = 0;
            end
            if (sst == 2 && !m_rvalid && $urandom_range(0, 99) >= gap_pct) begin
              m_rdata  = DW'($urandom);
              m_rresp  = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
              m_rlast  = (bi == nb - 1);
              m_rvalid = 1'b1;
              e.port = 8'(owner); e.id = m_rid; e.data = m_rdata;
              e.resp = m_rresp;   e.last = m_rlast;
              exp_r.push_back(e);
            end
          end
        endcase
      end
    end
  end

  // monitor: compare DUT against the model, then advance the model by this cycle's events
  always @(negedge clk) begin : mon
    int g;
    int idx;
    logic [NP-1:0] exp_rdy;
    ar_t a;
    r_t  e;
    logic mbeat;
    if (!rstn) begin
      chk("rst_m_arvalid", m_arvalid, 0);
      chk("rst_m_rready", m_rready, 0);
      chk("rst_s_arready", s_arready, 0);
      chk("rst_s_rvalid", s_rvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_grant_idx", grant_idx, 0);
      chk("rst_done_cnt", done_cnt, 0);
      chk("rst_len_err", len_err, 0);
      phase = 0; owner = 0; ptr = 0; mgrant = 0; beats = 0; mlen_err = 1'b0;
      for (int p = 0; p < NP; p++) mdone[p] = 0;
      exp_ar.delete(); exp_r.delete();
      ar_hs_n = '0; m_r_hs_n = 1'b0;
    end else begin
      chk("busy", busy, phase != 0);
      chk("grant_idx", grant_idx, mgrant);
      chk("len_err", len_err, mlen_err);
      for (int p = 0; p < NP; p++) chk("done_cnt", done_cnt[p*CW +: CW], mdone[p] % (1 << CW));

      g = -1;
      for (int k = 0; k < NP; k++) begin
        idx = (ptr + k) % NP;
        if (g < 0 && s_arvalid[idx]) g = idx;
      end
      exp_rdy = '0;
      if (phase == 0 && g >= 0) exp_rdy[g] = 1'b1;
      chk("s_arready", s_arready, exp_rdy);
      ar_hs_n = s_arvalid & s_arready;

      chk("m_arvalid", m_arvalid, phase == 1);
      if (phase == 1) begin
        if (exp_ar.size() == 0) chk("m_ar_expected", 1, 0);
        else begin
          a = {m_arid, m_araddr, m_arlen, m_arsize, m_arburst};
          chk("m_ar_fields", a, exp_ar[0]);
        end
        chk("m_ar_const", {m_arlock, m_arcache, m_arprot, m_arqos, m_arregion, m_aruser},
            {1'b0, 4'b0011, 3'b000, 4'b0000, 4'b0000, 1'b0});
      end

      chk("m_rready", m_rready, phase == 2 && s_rready[owner]);
      m_r_hs_n = m_rvalid & m_rready;

      for (int p = 0; p < NP; p++) begin
        if (s_rvalid[p] && s_rready[p]) begin
          if (exp_r.size() == 0) chk("r_unexpected", p, 8'hff);
          else begin
            e = exp_r.pop_front();
            chk("r_port", p, e.port);
            chk("r_id", s_rid[p*IW +: IW], e.id);
            chk("r_data", s_rdata[p*DW +: DW], e.data);
            chk("r_resp", s_rresp[p*2 +: 2], e.resp);
            chk("r_last", s_rlast[p], e.last);
          end
        end
        if (phase == 2 && p == owner) chk("r_valid_pass", s_rvalid[p], m_rvalid);
        else chk("r_other_zero", {s_rvalid[p], s_rlast[p], s_rresp[p*2 +: 2],
                                  s_rid[p*IW +: IW], s_rdata[p*DW +: DW]}, 0);
      end

      mbeat = (phase == 2) && m_rvalid && s_rready[owner];
      if (mbeat && (m_rlast ? (beats + 1 != mlen + 1) : (beats + 1 == mlen + 1))) mlen_err = 1'b1;
      else if (len_err_clr) mlen_err = 1'b0;

      if (phase == 0 && g >= 0) begin
        a.id = s_arid[g*IW +: IW]; a.addr = s_araddr[g*AW +: AW]; a.len = s_arlen[g*8 +: 8];
        a.size = s_arsize[g*3 +: 3]; a.burst = s_arburst[g*2 +: 2];
        exp_ar.push_back(a);
        grant_log.push_back(g);
        owner = g; mgrant = g; beats = 0; mlen = int'(a.len);
        phase = 1;
      end else if (phase == 1 && m_arready) begin
        void'(exp_ar.pop_front());
        phase = 2;
      end else if (mbeat) begin
        beats++;
        if (m_rlast) begin
          mdone[owner]++;
          ptr = (owner + 1) % NP;
          phase = 0;
        end
      end
    end
  end

  task automatic wait_idle(int budget);
    int  n = 0;
    bit  done = 0;
    bit  quiet;
    while (!done) begin
      @(negedge clk); #1;
      quiet = 1;
      for (int p = 0; p < NP; p++) if (req_left[p] != 0) quiet = 0;
      done = quiet && s_arvalid == '0 && phase == 0 && sst == 0 && exp_r.size() == 0;
      n++;
      if (!done && n >= budget) begin
        vectors++; errors++;
        $display("FAIL wait_idle: timeout after %0d cycles, phase %0d required 0", n, phase);
        done = 1;
      end
    end
  endtask

  task automatic chk_log(string nm, int n, int a, int b = 0, int c = 0, int d = 0);
    int e[4];
    e = '{a, b, c, d};
    chk({nm, "_count"}, grant_log.size(), n);
    for (int i = 0; i < n && i < grant_log.size(); i++) chk({nm, "_order"}, grant_log[i], e[i]);
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rstn = 1'b0;
    @(posedge clk); #3 rstn = 1'b1;
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1 len_err_clr = 1'b1;
    @(posedge clk); #1 len_err_clr = 1'b0;
    @(negedge clk); #1;
    chk("len_err_cleared", len_err, 0);
  endtask

  initial begin
    int n;
    len_err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #3 rstn = 1'b1;

    // single port burst
    fx_en = 1'b1; fx_id = 8'h05; fx_addr = 32'h1000; fx_len = 8'd3; eager = 1'b1;
    grant_log.delete();
    req_left[0] = 1;
    wait_idle(200);
    chk_log("single", 1, 0);
    chk("single_done0", done_cnt[CW-1:0], 1);
    chk("single_len_err", len_err, 0);

    // contention from rr_ptr 0
    do_reset();
    @(negedge clk); #1;
    grant_log.delete();
    fx_len = 8'd0;
    req_left[0] = 1; req_left[1] = 1; req_left[3] = 1;
    wait_idle(300);
    chk_log("contention", 3, 0, 1, 3);
    chk("contention_done", done_cnt, {16'd1, 16'd0, 16'd1, 16'd1});

    // fairness: port 2 served right after port 0's first burst
    grant_log.delete();
    req_left[0] = 3; req_left[2] = 1;
    wait_idle(400);
    chk_log("fairness", 4, 0, 2, 0, 0);

    // backpressure on AR and R
    fx_en = 1'b0; ar_delay_fixed = 5; rready_pct = 30;
    req_left[1] = 2;
    wait_idle(800);
    ar_delay_fixed = -1; rready_pct = 100;

    // early RLAST
    fx_en = 1'b1; fx_len = 8'd1; beats_override = 1;
    req_left[3] = 1;
    wait_idle(200);
    chk("early_rlast_len_err", len_err, 1);
    chk("early_rlast_idle", busy, 0);
    pulse_clr();

    // RLAST late: error at beat 2, exit at beat 3
    beats_override = 3;
    req_left[3] = 1;
    wait_idle(200);
    chk("late_rlast_len_err", len_err, 1);
    pulse_clr();
    beats_override = 0;

    // async reset mid-burst
    fx_len = 8'd7;
    req_left[2] = 1;
    n = 0;
    while (!(phase == 2 && beats >= 2) && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reset_reached_data", phase == 2, 1);
    @(posedge clk); #3 rstn = 1'b0;
    #1;
    chk("async_m_arvalid", m_arvalid, 0);
    chk("async_m_rready", m_rready, 0);
    chk("async_s_rvalid", s_rvalid, 0);
    chk("async_busy", busy, 0);
    chk("async_done_cnt", done_cnt, 0);
    chk("async_grant_idx", grant_idx, 0);
    @(posedge clk); #3 rstn = 1'b1;
    @(negedge clk); #1;
    grant_log.delete();
    fx_len = 8'd0;
    req_left[1] = 1; req_left[0] = 1;
    wait_idle(300);
    chk_log("post_reset", 2, 0, 1);

    // randomized traffic
    fx_en = 1'b0; eager = 1'b0; rready_pct = 70; gap_pct = 30;
    repeat (40) begin
      for (int p = 0; p < NP; p++) req_left[p] += $urandom_range(0, 2);
      beats_override = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8) : 0;
      repeat ($urandom_range(5, 40)) begin
        @(posedge clk); #1;
        len_err_clr = ($urandom_range(0, 15) == 0);
      end
    end
    @(posedge clk); #1 len_err_clr = 1'b0;
    beats_override = 0;
    wait_idle(20000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
